// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer: parallel-to-serial front end feeding the sequence detector's x input,
// with valid/ready word intake and zero-bubble back-to-back words.
module seq_bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             frame_start,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] sreg, sreg_n;
    logic             x_n, xv_n, fs_n, last, accept;
    assign last      = (state == SHIFT) && (cnt == CW'(WIDTH-1));
    assign din_ready = !reset && ((state == IDLE) || last);
    assign accept    = din_valid && din_ready;
    assign busy      = (state == SHIFT);
    // x is loaded with the first bit at the accepting edge so it appears one cycle later
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sreg_n  = sreg;
        x_n     = IDLE_BIT;
        xv_n    = 1'b0;
        fs_n    = 1'b0;
        if (accept) begin
            state_n = SHIFT;
            cnt_n   = '0;
            sreg_n  = din;
            x_n     = MSB_FIRST ? din[WIDTH-1] : din[0];
            xv_n    = 1'b1;
            fs_n    = 1'b1;
        end else if (state == SHIFT && !last) begin
            cnt_n  = cnt + 1'b1;
            sreg_n = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
            x_n    = MSB_FIRST ? sreg[WIDTH-2] : sreg[1];
            xv_n   = 1'b1;
        end else if (last) begin
            state_n = IDLE;
            cnt_n   = '0;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            sreg        <= '0;
            x           <= IDLE_BIT;
            x_valid     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            sreg        <= sreg_n;
            x           <= x_n;
            x_valid     <= xv_n;
            frame_start <= fs_n;
        end
    end
endmodule
